base_sampler: RTL

BASE_SAMPLER -- requirements
Module: base_sampler

---
 rtl/sampler_pkg.sv | 37 +++
 rtl/int_to_double.sv | 29 ++
 rtl/base_sampler.sv | 125 ++++++++++++
 3 files changed

// File: rtl/sampler_pkg.sv
// Shared definitions for the Gaussian base sampler and the downstream x-computation stage:
// the FALCON reverse cumulative distribution table, default sizes and the sampler state type.
package sampler_pkg;

  localparam int RCDT_N_DEF = 18;
  localparam int RCDT_W_DEF = 72;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    CONV,
    OUT
  } sampler_state_e;

  // Strictly descending; a sample's z0 is the number of entries greater than u.
  localparam logic [71:0] RCDT_TABLE [RCDT_N_DEF] = '{
    72'd3024686241123004913666,
    72'd1564742784480091954050,
    72'd636254429462080897535,
    72'd199560484645026482916,
    72'd47667343854657281903,
    72'd8595902006365044063,
    72'd1163297957344668388,
    72'd117656387352093658,
    72'd8867391802663976,
    72'd496969357462633,
    72'd20680885154299,
    72'd638331848991,
    72'd14602316184,
    72'd247426747,
    72'd3104126,
    72'd28824,
    72'd198,
    72'd1
  };

endpackage

// File: rtl/int_to_double.sv
// Exact conversion of a 10-bit two's-complement integer to an IEEE-754 double.
// Zero maps to +0.0; every representable input fits the 52-bit fraction without rounding.
module int_to_double (
  input  logic [9:0]  a,
  output logic [63:0] d
);

  logic       sign;
  logic [9:0] mag;
  logic [3:0] msb;
  logic [8:0] frac_hi;
  logic [10:0] expo;

  // NOTE: every signal written here gets a value before any conditional, so no latch is inferred.
  always_comb begin
    sign = a[9];
    mag  = sign ? (10'd0 - a) : a;
    msb  = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (mag[i]) msb = 4'(i);
    end
    // Normalise so the leading one sits at bit 9; it becomes the hidden bit and is dropped.
    frac_hi = 9'(mag << (4'd9 - msb));
    expo    = 11'd1023 + {7'd0, msb};
    if (mag == 10'd0) d = 64'd0;
    else              d = {sign, expo, frac_hi, 43'd0};
  end

endmodule

// File: rtl/base_sampler.sv
// Constant-time FALCON base sampler: scans the full RCDT for every request, then emits the
// signed sample z and z0*z0 as doubles through a stb/ack handshake.
module base_sampler
  import sampler_pkg::*;
#(
  parameter int RCDT_N = RCDT_N_DEF,
  parameter int RCDT_W = RCDT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stb,
  output logic              ack,
  input  logic [RCDT_W-1:0] u,
  input  logic              b,
  output logic [63:0]       z,
  output logic [63:0]       z0square,
  output logic              z_stb,
  input  logic              z_ack
);

  localparam logic [4:0] LAST_IDX = 5'(RCDT_N - 1);

  sampler_state_e    state_q, state_d;
  logic              ack_q, ack_d;
  logic              z_stb_q, z_stb_d;
  logic [RCDT_W-1:0] u_q, u_d;
  logic              b_q, b_d;
  logic [4:0]        z0_q, z0_d;
  logic [4:0]        idx_q, idx_d;
  logic [63:0]       z_q, z_d;
  logic [63:0]       z0sq_q, z0sq_d;

  logic [5:0]  z_int;
  logic [8:0]  z0sq_int;
  logic [63:0] z_dbl, z0sq_dbl;

  // z = b + (2b-1)*z0, i.e. z0+1 for b=1 and -z0 for b=0.
  assign z_int    = b_q ? ({1'b0, z0_q} + 6'd1) : (6'd0 - {1'b0, z0_q});
  assign z0sq_int = {4'd0, z0_q} * {4'd0, z0_q};

  int_to_double u_conv_z (
    .a ({{4{z_int[5]}}, z_int}),
    .d (z_dbl)
  );

  int_to_double u_conv_sq (
    .a ({1'b0, z0sq_int}),
    .d (z0sq_dbl)
  );

  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    z_stb_d = z_stb_q;
    u_d     = u_q;
    b_d     = b_q;
    z0_d    = z0_q;
    idx_d   = idx_q;
    z_d     = z_q;
    z0sq_d  = z0sq_q;
    unique case (state_q)
      IDLE: begin
        if (stb && ack_q) begin
          u_d     = u;
          b_d     = b;
          z0_d    = 5'd0;
          idx_d   = 5'd0;
          ack_d   = 1'b0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        // No early exit: all entries are visited so timing does not leak u.
        if (u_q < RCDT_W'(RCDT_TABLE[idx_q])) z0_d = z0_q + 5'd1;
        idx_d = idx_q + 5'd1;
        if (idx_q == LAST_IDX) state_d = CONV;
      end
      CONV: begin
        z_d     = z_dbl;
        z0sq_d  = z0sq_dbl;
        z_stb_d = 1'b1;
        state_d = OUT;
      end
      OUT: begin
        if (z_ack) begin
          z_stb_d = 1'b0;
          ack_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated only with non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ack_q   <= 1'b1;
      z_stb_q <= 1'b0;
      u_q     <= '0;
      b_q     <= 1'b0;
      z0_q    <= 5'd0;
      idx_q   <= 5'd0;
      z_q     <= 64'd0;
      z0sq_q  <= 64'd0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      z_stb_q <= z_stb_d;
      u_q     <= u_d;
      b_q     <= b_d;
      z0_q    <= z0_d;
      idx_q   <= idx_d;
      z_q     <= z_d;
      z0sq_q  <= z0sq_d;
    end
  end

  assign ack      = ack_q;
  assign z_stb    = z_stb_q;
  assign z        = z_q;
  assign z0square = z0sq_q;

endmodule
